// File: rtl/c17_lane_pipe_if.sv
// c17_lane_pipe_if: valid/ready handshake, per-lane c17 pins and toggle counter of c17_lane_pipe
interface c17_lane_pipe_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [LANES-1:0] N1, N2, N3, N6, N7, N22, N23;
  logic [CNT_W-1:0] toggle_cnt;
  modport master (
    output in_valid, N1, N2, N3, N6, N7, out_ready, clr_cnt,
    input in_ready, out_valid, N22, N23, toggle_cnt
  );
  modport slave (
    input in_valid, N1, N2, N3, N6, N7, out_ready, clr_cnt,
    output in_ready, out_valid, N22, N23, toggle_cnt
  );
endinterface

// File: rtl/c17_lane_pipe.sv
// c17_lane_pipe: LANES independent c17 slices behind a 1/2-stage valid/ready pipe with a saturating output-toggle counter
module c17_lane_pipe #(
  parameter int LANES = 4,
  parameter int PIPE = 2,
  parameter int CNT_W = 16
) (
  input logic CK,
  input logic RST,
  c17_lane_pipe_if.slave bus
);
  logic [LANES-1:0] n8, n9, n10, n11, n12, d22, d23, q22, q23;
  logic [2*LANES-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic vo, load_o, load_1, src_v, xfer;
  always_comb begin
    n10 = ~(bus.N3 & bus.N6);
    n11 = ~(bus.N1 & bus.N3);
    n12 = ~(bus.N2 & n10);
    n8 = ~n10;
    n9 = ~(bus.N2 | bus.N7);
  end
  assign load_o = ~vo | bus.out_ready;
  assign xfer = vo & bus.out_ready;
  generate
    if (PIPE == 2) begin : g_two
      logic v1;
      logic [LANES-1:0] s8, s9, s11, s12;
      assign load_1 = ~v1 | load_o;
      assign src_v = v1;
      assign d22 = ~(s11 & s12);
      assign d23 = ~(s8 | s9);
      always_ff @(posedge CK or posedge RST)
        if (RST) v1 <= 1'b0;
        else if (load_1) v1 <= bus.in_valid;
      always_ff @(posedge CK)
        if (load_1 && bus.in_valid) begin
          s8 <= n8;
          s9 <= n9;
          s11 <= n11;
          s12 <= n12;
        end
    end else if (PIPE == 1) begin : g_one
      assign load_1 = load_o;
      assign src_v = bus.in_valid;
      assign d22 = ~(n11 & n12);
      assign d23 = ~(n8 | n9);
    end else begin : g_bad
      $error("c17_lane_pipe: PIPE must be 1 or 2");
    end
  endgenerate
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      vo <= 1'b0;
      q22 <= '0;
      q23 <= '0;
    end else if (load_o) begin
      vo <= src_v;
      q22 <= src_v ? d22 : q22;
      q23 <= src_v ? d23 : q23;
    end
  // last survives clr_cnt so the toggle history stays continuous across clears
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      cnt <= '0;
      last <= '0;
    end else begin
      cnt <= bus.clr_cnt ? '0 : (xfer && {q22, q23} != last && cnt != '1) ? cnt + 1'b1 : cnt;
      last <= xfer ? {q22, q23} : last;
    end
  assign bus.in_ready = ~RST & load_1;
  assign bus.out_valid = vo;
  assign bus.N22 = q22;
  assign bus.N23 = q23;
  assign bus.toggle_cnt = cnt;
endmodule

// File: tb/tb_c17_lane_pipe.sv
// tb_c17_lane_pipe: table, directed and random checks of c17_lane_pipe against a queue-based model
module tb_c17_lane_pipe;
  typedef struct { logic [3:0] n1, n2, n3, n6, n7, e22, e23; } vec_t;
  typedef struct { logic [7:0] w; int t; } ent_t;
  logic CK = 1'b0, RST = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [3:0] n1 = '0, n2 = '0, n3 = '0, n6 = '0, n7 = '0;
  int checks = 0, failures = 0, cyc_n = 0, m0 = 0, m1 = 0, pushed = 0, popped = 0, low_ir = 0;
  logic [7:0] last = '0;
  ent_t q[$];
  vec_t tbl[8];
  always #5 CK = ~CK;
  c17_lane_pipe_if #(.LANES(4), .CNT_W(16)) b0 ();
  c17_lane_pipe_if #(.LANES(4), .CNT_W(4)) b1 ();
  c17_lane_pipe_if #(.LANES(1), .CNT_W(16)) b2 ();
  assign b0.in_valid = in_valid; assign b0.out_ready = out_ready; assign b0.clr_cnt = clr_cnt;
  assign b0.N1 = n1; assign b0.N2 = n2; assign b0.N3 = n3; assign b0.N6 = n6; assign b0.N7 = n7;
  assign b1.in_valid = in_valid; assign b1.out_ready = out_ready; assign b1.clr_cnt = clr_cnt;
  assign b1.N1 = n1; assign b1.N2 = n2; assign b1.N3 = n3; assign b1.N6 = n6; assign b1.N7 = n7;
  assign b2.in_valid = in_valid; assign b2.out_ready = out_ready; assign b2.clr_cnt = clr_cnt;
  assign b2.N1 = n1[0]; assign b2.N2 = n2[0]; assign b2.N3 = n3[0]; assign b2.N6 = n6[0]; assign b2.N7 = n7[0];
  c17_lane_pipe #(.LANES(4), .PIPE(2), .CNT_W(16)) dut0 (.CK(CK), .RST(RST), .bus(b0.slave));
  c17_lane_pipe #(.LANES(4), .PIPE(2), .CNT_W(4)) dut1 (.CK(CK), .RST(RST), .bus(b1.slave));
  c17_lane_pipe #(.LANES(1), .PIPE(1), .CNT_W(16)) dut2 (.CK(CK), .RST(RST), .bus(b2.slave));

  // c17 as sum-of-products: {N22, N23} per lane
  function automatic logic [7:0] c17(input logic [3:0] a1, a2, a3, a6, a7);
    logic [3:0] y22, y23;
    y22 = (a1 & a3) | (a2 & ~(a3 & a6));
    y23 = ~(a3 & a6) & (a2 | a7);
    return {y22, y23};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc_n = 0; m0 = 0; m1 = 0; last = '0; pushed = 0; popped = 0; low_ir = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 1; clr_cnt = 0; {n1, n2, n3, n6, n7} = '0;
    RST = 1;
    @(posedge CK); #1;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_in_ready", b0.in_ready, 0);
    chk("rst_cnt", b0.toggle_cnt, 0);
    chk("rst_data", {b0.N22, b0.N23}, 0);
    @(negedge CK);
    RST = 0;
    model_reset();
    #1 chk("rel_in_ready", b0.in_ready, 1);
  endtask

  // A 2-deep FIFO in which each word becomes visible two edges after acceptance
  task automatic cyc();
    logic ir, ov;
    #1;
    ir = !(q.size() == 2 && !out_ready);
    ov = q.size() > 0 && cyc_n - q[0].t >= 2;
    if (b0.in_ready === 1'b0) low_ir++;
    chk("in_ready", b0.in_ready, ir);
    chk("out_valid", b0.out_valid, ov);
    if (ov) chk("data", {b0.N22, b0.N23}, q[0].w);
    chk("cnt16", b0.toggle_cnt, m0);
    chk("cnt4", b1.toggle_cnt, m1);
    if (ov && out_ready) begin
      if (q[0].w != last) begin
        m0 = (m0 == 65535) ? m0 : m0 + 1;
        m1 = (m1 == 15) ? m1 : m1 + 1;
      end
      last = q[0].w;
      void'(q.pop_front());
      popped++;
    end
    if (clr_cnt) begin m0 = 0; m1 = 0; end
    if (in_valid && ir) begin
      q.push_back('{c17(n1, n2, n3, n6, n7), cyc_n});
      pushed++;
    end
    @(negedge CK);
    cyc_n++;
  endtask

  initial begin
    tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
    tbl[2] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    tbl[3] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[4] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    tbl[5] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[6] = '{4'hA, 4'h5, 4'hC, 4'h6, 4'h9, 4'h9, 4'h9};
    tbl[7] = '{4'h3, 4'h0, 4'hF, 4'h3, 4'hE, 4'h3, 4'hC};
    // truth table streamed back-to-back, two-cycle latency
    do_reset();
    for (int j = 0; j < 10; j++) begin
      in_valid = j < 8;
      if (j < 8) {n1, n2, n3, n6, n7} = {tbl[j].n1, tbl[j].n2, tbl[j].n3, tbl[j].n6, tbl[j].n7};
      #1;
      if (j >= 2) begin
        chk("tbl_valid", b0.out_valid, 1);
        chk("tbl_n22", b0.N22, tbl[j-2].e22);
        chk("tbl_n23", b0.N23, tbl[j-2].e23);
      end else chk("tbl_latency", b0.out_valid, 0);
      if (j == 3) chk("tbl_cnt0", b0.toggle_cnt, 0);
      if (j == 4) chk("tbl_cnt1", b0.toggle_cnt, 1);
      cyc();
    end
    // ten words with a four-cycle downstream stall
    do_reset();
    for (int j = 0; j < 18; j++) begin
      in_valid = pushed < 10;
      {n1, n2, n3, n6, n7} = 20'($urandom);
      out_ready = !(j >= 3 && j <= 6);
      cyc();
    end
    chk("stall_in_ready_low", low_ir, 4);
    chk("stall_popped", popped, 10);
    chk("stall_empty", q.size(), 0);
    // randomized traffic, stalls and clears
    do_reset();
    for (int j = 0; j < 400; j++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      clr_cnt = $urandom_range(0, 31) == 0;
      {n1, n2, n3, n6, n7} = 20'($urandom);
      cyc();
    end
    in_valid = 0; out_ready = 1; clr_cnt = 0;
    for (int j = 0; j < 4; j++) cyc();
    chk("rand_drained", q.size(), 0);
    chk("rand_balance", popped, pushed);
    // saturation on the 4-bit counter, then clear racing a transfer
    do_reset();
    for (int j = 0; j < 22; j++) begin
      in_valid = j < 20;
      {n1, n2, n3, n6, n7} = {16'h0, (j % 2 == 1) ? 4'hF : 4'h0};
      cyc();
    end
    chk("sat_cnt4", b1.toggle_cnt, 15);
    chk("sat_cnt16", b0.toggle_cnt, 19);
    for (int j = 0; j < 5; j++) begin
      in_valid = j < 2;
      {n1, n2, n3, n6, n7} = {4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
      clr_cnt = j == 2;
      cyc();
      if (j == 2) begin
        #1;
        chk("clr_cnt4", b1.toggle_cnt, 0);
        chk("clr_cnt16", b0.toggle_cnt, 0);
      end
    end
    clr_cnt = 0;
    // reset with two words in flight
    do_reset();
    in_valid = 1;
    {n1, n2, n3, n6, n7} = '1;
    cyc();
    cyc();
    in_valid = 0;
    #1 chk("pre_rst_valid", b0.out_valid, 1);
    RST = 1;
    #1;
    chk("async_out_valid", b0.out_valid, 0);
    chk("async_in_ready", b0.in_ready, 0);
    chk("async_data", {b0.N22, b0.N23}, 0);
    @(negedge CK);
    RST = 0;
    model_reset();
    #1 chk("post_rst_in_ready", b0.in_ready, 1);
    for (int j = 0; j < 4; j++) cyc();
    // single-stage, single-lane instance
    do_reset();
    for (int j = 0; j <= 8; j++) begin
      in_valid = j < 8;
      if (j < 8) {n1, n2, n3, n6, n7} = {tbl[j].n1, tbl[j].n2, tbl[j].n3, tbl[j].n6, tbl[j].n7};
      #1;
      chk("p1_in_ready", b2.in_ready, 1);
      if (j == 0) chk("p1_latency", b2.out_valid, 0);
      else begin
        chk("p1_valid", b2.out_valid, 1);
        chk("p1_n22", b2.N22, tbl[j-1].e22[0]);
        chk("p1_n23", b2.N23, tbl[j-1].e23[0]);
      end
      if (j == 2) chk("p1_cnt0", b2.toggle_cnt, 0);
      if (j == 3) chk("p1_cnt1", b2.toggle_cnt, 1);
      @(negedge CK);
    end
    #1 chk("p1_drained", b2.out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
